// File: rtl/cook_ctrl_pkg.sv
// Shared definitions for the cooking timer controller: state encoding and
// the digit limits and DONE hold time that the controller enforces.
package cook_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEntry   = 3'd1,
    StRunning = 3'd2,
    StPaused  = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned DONE_TICKS   = 3;

  localparam int unsigned DigitW = 4;
  localparam int unsigned EntryW = 3 * DigitW;

  // A keypad code is a usable BCD digit only in the range 0..DIGIT_MAX.
  function automatic logic digit_valid(input logic [DigitW-1:0] d);
    return d <= DigitW'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/cook_ctrl_key_entry.sv
// Three-digit {min, sec_tens, sec_ones} entry shift register. Accepted digits
// enter at sec_ones and push the older digits left, dropping the old minute.
module key_entry
  import cook_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              key_valid,
  input  logic [DigitW-1:0] key_digit,
  input  logic              key_en,
  input  logic              entry_clr,
  output logic              key_accept,
  output logic [EntryW-1:0] entry
);

  logic [EntryW-1:0] entry_d, entry_q;

  assign key_accept = key_valid & key_en & digit_valid(key_digit);

  always_comb begin
    entry_d = entry_q;
    if (entry_clr) begin
      entry_d = '0;
    end else if (key_accept) begin
      entry_d = {entry_q[EntryW-DigitW-1:0], key_digit};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/cook_ctrl.sv
// Microwave cook controller: keypad entry, start/stop/pause sequencing of an
// external BCD down-counter, magnetron enable and a timed DONE indication.
module cook_ctrl
  import cook_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              door_closed,
  input  logic              key_valid,
  input  logic [DigitW-1:0] key_digit,
  input  logic              timer_zero,
  output logic [EntryW-1:0] load_data,
  output logic              timer_loadn,
  output logic              timer_clrn,
  output logic              timer_en,
  output logic              mag_on,
  output logic              done,
  output logic [2:0]        state
);

  state_e     state_d, state_q;
  logic [1:0] done_cnt_d, done_cnt_q;
  logic       timer_loadn_d, timer_loadn_q;
  logic       timer_clrn_d, timer_clrn_q;
  logic       mag_on_d, mag_on_q;

  logic              ev_clear, ev_door, ev_stop, ev_start;
  logic              key_en, key_accept, entry_clr, start_ok;
  logic [EntryW-1:0] entry;

  // Only the highest-priority event present in a cycle is visible to the FSM.
  assign ev_clear = clear;
  assign ev_door  = ~clear & ~door_closed;
  assign ev_stop  = ~clear & door_closed & stop;
  assign ev_start = ~clear & door_closed & ~stop & start;
  assign key_en   = ~clear & door_closed & ~stop & ~start &
                    ((state_q == StIdle) | (state_q == StEntry));

  assign start_ok = ev_start & (state_q == StEntry) & (entry != '0) &
                    (entry[2*DigitW-1:DigitW] <= DigitW'(SEC_TENS_MAX));

  key_entry u_key_entry (
    .clk        (clk),
    .clrn       (clrn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_en     (key_en),
    .entry_clr  (entry_clr),
    .key_accept (key_accept),
    .entry      (entry)
  );

  always_comb begin
    state_d       = state_q;
    done_cnt_d    = done_cnt_q;
    timer_loadn_d = 1'b1;
    entry_clr     = 1'b0;

    if (ev_clear) begin
      state_d   = StIdle;
      entry_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StEntry: begin
          if (start_ok) begin
            state_d       = StRunning;
            timer_loadn_d = 1'b0;
          end else if (key_accept) begin
            state_d = StEntry;
          end
        end
        StRunning: begin
          if (ev_door | ev_stop) begin
            state_d = StPaused;
          end else if (timer_zero) begin
            state_d = StDone;
          end
        end
        StPaused: begin
          if (ev_stop) begin
            state_d   = StIdle;
            entry_clr = 1'b1;
          end else if (ev_start) begin
            // Resume from the count already held in the timer chain.
            state_d = StRunning;
          end
        end
        StDone: begin
          if (ev_door) begin
            state_d = StIdle;
          end else if (tick) begin
            if (done_cnt_q == 2'(DONE_TICKS - 1)) begin
              state_d = StIdle;
            end else begin
              done_cnt_d = done_cnt_q + 2'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_d != StDone) begin
      done_cnt_d = '0;
    end
    timer_clrn_d = ~entry_clr;
    mag_on_d     = (state_d == StRunning);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= StIdle;
      done_cnt_q    <= '0;
      timer_loadn_q <= 1'b1;
      timer_clrn_q  <= 1'b1;
      mag_on_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_cnt_q    <= done_cnt_d;
      timer_loadn_q <= timer_loadn_d;
      timer_clrn_q  <= timer_clrn_d;
      mag_on_q      <= mag_on_d;
    end
  end

  assign load_data   = entry;
  assign timer_loadn = timer_loadn_q;
  assign timer_clrn  = timer_clrn_q;
  assign mag_on      = mag_on_q;
  assign done        = (state_q == StDone);
  assign timer_en    = tick & (state_q == StRunning) & ~timer_zero;
  assign state       = state_q;

endmodule

// File: tb/tb_cook_ctrl.sv
// Bench for cook_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a digit-level behavioural model of the cook controller.
module tb_cook_ctrl;

  logic        clk, clrn;
  logic        tick, start, stop, clear, door_closed, key_valid, timer_zero;
  logic [3:0]  key_digit;
  logic [11:0] load_data;
  logic        timer_loadn, timer_clrn, timer_en, mag_on, done;
  logic [2:0]  state;

  cook_ctrl dut (
    .clk         (clk),
    .clrn        (clrn),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .timer_zero  (timer_zero),
    .load_data   (load_data),
    .timer_loadn (timer_loadn),
    .timer_clrn  (timer_clrn),
    .timer_en    (timer_en),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  // Model: 0 idle, 1 entry, 2 running, 3 paused, 4 done; digits [0]=min..[2]=ones.
  int m_st, m_cnt, m_dig[3], m_loadn, m_clrn, m_mag;
  int n_st, n_cnt, n_dig[3], n_loadn, n_clrn, n_mag;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_dig = '{0, 0, 0};
    m_loadn = 1; m_clrn = 1; m_mag = 0;
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_st);
    chk("load_data", int'(load_data), m_dig[0] * 256 + m_dig[1] * 16 + m_dig[2]);
    chk("timer_loadn", int'(timer_loadn), m_loadn);
    chk("timer_clrn", int'(timer_clrn), m_clrn);
    chk("mag_on", int'(mag_on), m_mag);
    chk("done", int'(done), (m_st == 4) ? 1 : 0);
    chk("timer_en", int'(timer_en), (tick && m_st == 2 && !timer_zero) ? 1 : 0);
  endtask

  task automatic model_next();
    int ev;
    bit all_zero;
    if (clear) ev = 1;
    else if (!door_closed) ev = 2;
    else if (stop) ev = 3;
    else if (start) ev = 4;
    else if (key_valid) ev = 5;
    else ev = 0;
    all_zero = (m_dig[0] == 0 && m_dig[1] == 0 && m_dig[2] == 0);
    n_st = m_st; n_cnt = m_cnt; n_dig = m_dig; n_loadn = 1; n_clrn = 1;
    if (ev == 1) begin
      n_st = 0; n_clrn = 0; n_dig = '{0, 0, 0};
    end else if (m_st == 0 || m_st == 1) begin
      if (m_st == 1 && ev == 4 && !all_zero && m_dig[1] <= 5) begin
        n_st = 2; n_loadn = 0;
      end else if (ev == 5 && key_digit <= 9) begin
        n_dig = '{m_dig[1], m_dig[2], int'(key_digit)};
        n_st = 1;
      end
    end else if (m_st == 2) begin
      if (ev == 2 || ev == 3) n_st = 3;
      else if (timer_zero) n_st = 4;
    end else if (m_st == 3) begin
      if (ev == 3) begin
        n_st = 0; n_clrn = 0; n_dig = '{0, 0, 0};
      end else if (ev == 4) n_st = 2;
    end else if (m_st == 4) begin
      if (ev == 2) n_st = 0;
      else if (tick) begin
        if (m_cnt + 1 == 3) n_st = 0;
        else n_cnt = m_cnt + 1;
      end
    end
    if (n_st != 4) n_cnt = 0;
    n_mag = (n_st == 2) ? 1 : 0;
  endtask

  // Called at a negedge after inputs are driven; returns at the next negedge.
  task automatic step();
    #1;
    compare_all();
    model_next();
    @(posedge clk);
    m_st = n_st; m_cnt = n_cnt; m_dig = n_dig;
    m_loadn = n_loadn; m_clrn = n_clrn; m_mag = n_mag;
    @(negedge clk);
  endtask

  task automatic idle_in();
    tick = 0; start = 0; stop = 0; clear = 0; key_valid = 0;
    key_digit = 0; timer_zero = 0; door_closed = 1;
  endtask

  task automatic key(input int d);
    idle_in(); key_valid = 1; key_digit = 4'(d); step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    clrn = 0;
    model_reset();
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_loadn", int'(timer_loadn), 1);
    chk("rst_clrn", int'(timer_clrn), 1);
    chk("rst_mag", int'(mag_on), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    clrn = 1;

    // Keys 1,3,0 then a valid start.
    key(1); key(3); key(0);
    chk("lit_load_130", int'(load_data), 12'h130);
    idle_in(); start = 1; step();
    chk("lit_run_state", int'(state), 2);
    chk("lit_run_loadn", int'(timer_loadn), 0);
    chk("lit_run_mag", int'(mag_on), 1);
    idle_in(); tick = 1; #1;
    chk("lit_en_tick", int'(timer_en), 1);
    step();
    chk("lit_loadn_back", int'(timer_loadn), 1);
    idle_in(); #1;
    chk("lit_en_notick", int'(timer_en), 0);
    step();

    // Door opens: pause; close then start: resume without reload.
    idle_in(); door_closed = 0; step();
    chk("lit_pause_state", int'(state), 3);
    chk("lit_pause_mag", int'(mag_on), 0);
    idle_in(); step();
    idle_in(); start = 1; step();
    chk("lit_resume_state", int'(state), 2);
    chk("lit_resume_loadn", int'(timer_loadn), 1);

    // Asynchronous reset while running, between clock edges.
    idle_in(); tick = 1;
    #2 clrn = 0;
    #1;
    chk("lit_arst_state", int'(state), 0);
    chk("lit_arst_mag", int'(mag_on), 0);
    chk("lit_arst_loadn", int'(timer_loadn), 1);
    chk("lit_arst_en", int'(timer_en), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clrn = 1;
    key(4);
    chk("lit_post_rst", int'(state), 1);
    chk("lit_post_rst_ld", int'(load_data), 12'h004);

    // Invalid seconds-tens digit blocks start.
    idle_in(); clear = 1; step();
    key(0); key(7); key(5);
    chk("lit_load_075", int'(load_data), 12'h075);
    idle_in(); start = 1; step();
    chk("lit_bad_state", int'(state), 1);
    chk("lit_bad_loadn", int'(timer_loadn), 1);
    chk("lit_bad_mag", int'(mag_on), 0);

    // Start and clear together: clear wins.
    idle_in(); start = 1; clear = 1; step();
    chk("lit_clr_state", int'(state), 0);
    chk("lit_clr_clrn", int'(timer_clrn), 0);
    chk("lit_clr_load", int'(load_data), 0);
    idle_in(); step();
    chk("lit_clrn_back", int'(timer_clrn), 1);

    // Run to zero, then DONE holds for three ticks.
    key(1); key(0);
    idle_in(); start = 1; step();
    idle_in(); timer_zero = 1; step();
    chk("lit_done_state", int'(state), 4);
    chk("lit_done_flag", int'(done), 1);
    chk("lit_done_mag", int'(mag_on), 0);
    idle_in(); tick = 1; step();
    idle_in(); step();
    idle_in(); tick = 1; step();
    chk("lit_done_hold", int'(state), 4);
    idle_in(); tick = 1; step();
    chk("lit_done_exit", int'(state), 0);
    chk("lit_done_off", int'(done), 0);
    chk("lit_entry_kept", int'(load_data), 12'h010);
    key(12);
    chk("lit_bad_digit_st", int'(state), 0);
    chk("lit_bad_digit_ld", int'(load_data), 12'h010);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      idle_in();
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      door_closed = ($urandom_range(0, 19) != 0);
      key_valid   = ($urandom_range(0, 3) == 0);
      key_digit   = 4'($urandom_range(0, 15));
      tick        = ($urandom_range(0, 2) == 0);
      timer_zero  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
